// File: rtl/rggen_host_adapter_pkg.sv
// ----------------------------------------------------------------------------
// rggen_rtl_pkg
//
// Shared types for the rggen register access path, plus the additions used by
// the host adapter.
//
// Contents:
//   rggen_status       - response code returned by a register slot
//   rggen_direction    - access direction driven towards the slots
//   rggen_host_state   - host adapter sequencing states (IDLE/BUSY/RESPONSE)
//   rggen_strobe_to_mask(strobe)
//                      - expands one byte-lane strobe bit into an 8-bit mask
//                        lane; callers build a full write mask lane by lane
//
// Optional feature macro used by consumers of this package:
//   RGGEN_HOST_ADAPTER_TIMEOUT_EN (see rggen_host_adapter)
// ----------------------------------------------------------------------------
package rggen_rtl_pkg;

   typedef enum logic [1:0] {
      RGGEN_OKAY         = 2'b00,
      RGGEN_EXOKAY       = 2'b01,
      RGGEN_SLAVE_ERROR  = 2'b10,
      RGGEN_DECODE_ERROR = 2'b11
   } rggen_status;

   typedef enum logic {
      RGGEN_READ  = 1'b0,
      RGGEN_WRITE = 1'b1
   } rggen_direction;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      BUSY     = 2'b01,
      RESPONSE = 2'b10
   } rggen_host_state;

   // The expansion is done per byte lane so the function stays independent of
   // the data width of whichever block calls it.
   function automatic logic [7:0] rggen_strobe_to_mask(input logic strobe);
      return {8{strobe}};
   endfunction

endpackage

// File: rtl/rggen_host_adapter_if.sv
// ----------------------------------------------------------------------------
// rggen_register_if
//
// Connection between one host-side initiator and one register slot.
//
// Parameters:
//   ADDRESS_WIDTH - byte address width
//   DATA_WIDTH    - data width (multiple of 8)
//
// Signals:
//   request     master -> slave  access in progress
//   address     master -> slave  byte address
//   direction   master -> slave  RGGEN_READ / RGGEN_WRITE
//   write_data  master -> slave  write data
//   write_mask  master -> slave  bit-level write enables
//   select      slave  -> master slot decodes the address
//   ready       slave  -> master slot completes the access this cycle
//   read_data   slave  -> master read data
//   status      slave  -> master access status
//
// Modports: master (the host adapter), slave (a register block).
// ----------------------------------------------------------------------------
interface rggen_register_if #(
   parameter int ADDRESS_WIDTH = 16,
   parameter int DATA_WIDTH    = 32
);
   import rggen_rtl_pkg::*;

   logic                     request;
   logic [ADDRESS_WIDTH-1:0] address;
   rggen_direction           direction;
   logic [DATA_WIDTH-1:0]    write_data;
   logic [DATA_WIDTH-1:0]    write_mask;
   logic                     select;
   logic                     ready;
   logic [DATA_WIDTH-1:0]    read_data;
   rggen_status              status;

   modport master (
      output request, address, direction, write_data, write_mask,
      input  select, ready, read_data, status
   );

   modport slave (
      input  request, address, direction, write_data, write_mask,
      output select, ready, read_data, status
   );

endinterface

// File: rtl/rggen_host_adapter_response_collector.sv
// ----------------------------------------------------------------------------
// rggen_response_collector
//
// Purely combinational merge of the per-slot response signals.
//
// Parameters:
//   REGISTERS  - number of slots
//   DATA_WIDTH - read data width
//
// Ports:
//   select, ready   in  per-slot decode and completion flags
//   read_data       in  per-slot read data
//   status          in  per-slot status
//   hit             out some selected slot is ready
//   multi_select    out more than one slot selected
//   no_select       out no slot selected
//   merged_data     out AND-OR of read data, gated by select
//   merged_status   out AND-OR of status, gated by select
// ----------------------------------------------------------------------------
module rggen_response_collector
   import rggen_rtl_pkg::*;
#(
   parameter int REGISTERS  = 1,
   parameter int DATA_WIDTH = 32
) (
   input  logic [REGISTERS-1:0]                 select,
   input  logic [REGISTERS-1:0]                 ready,
   input  logic [REGISTERS-1:0][DATA_WIDTH-1:0] read_data,
   input  rggen_status                          status [REGISTERS],
   output logic                                 hit,
   output logic                                 multi_select,
   output logic                                 no_select,
   output logic [DATA_WIDTH-1:0]                merged_data,
   output rggen_status                          merged_status
);

   logic [1:0] status_bits;

   assign hit          = |(select & ready);
   assign no_select    = (select == '0);
   // Clearing the lowest set bit leaves something only when two or more
   // slots are selected.
   assign multi_select = ((select & (select - REGISTERS'(1))) != '0);

   // Unselected slots may drive anything on their response lines, so every
   // contribution is masked by that slot's select before being ORed in.
   always_comb begin
      merged_data = '0;
      status_bits = '0;
      for (int i = 0; i < REGISTERS; i++) begin
         merged_data = merged_data | (read_data[i] & {DATA_WIDTH{select[i]}});
         status_bits = status_bits | (status[i] & {2{select[i]}});
      end
   end

   assign merged_status = rggen_status'(status_bits);

endmodule

// File: rtl/rggen_host_adapter.sv
// ----------------------------------------------------------------------------
// rggen_host_adapter
//
// Host-side initiator for rggen_register_if. Takes one command at a time on a
// valid/ready channel, broadcasts it to every register slot, collects the
// slot answers and returns a single response on a valid/ready channel.
//
// Parameters:
//   ADDRESS_WIDTH  - byte address width
//   DATA_WIDTH     - data width, multiple of 8
//   REGISTERS      - number of attached slots
//   TIMEOUT_CYCLES - BUSY cycle limit, only with RGGEN_HOST_ADAPTER_TIMEOUT_EN
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_command_valid/o_command_ready, i_address, i_write, i_write_data,
//   i_strobe                     command channel
//   o_response_valid/i_response_ready, o_read_data, o_status
//                                response channel
//   register_if[REGISTERS]       master side of every slot
//
// Optional feature macro: RGGEN_HOST_ADAPTER_TIMEOUT_EN
//   Defined   - a BUSY cycle counter forces SLAVE_ERROR after TIMEOUT_CYCLES.
//   Undefined - BUSY waits indefinitely for a selected slot to become ready.
// ----------------------------------------------------------------------------
module rggen_host_adapter
   import rggen_rtl_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 16,
   parameter int DATA_WIDTH     = 32,
   parameter int REGISTERS      = 1,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_command_valid,
   output logic                       o_command_ready,
   input  logic [ADDRESS_WIDTH-1:0]   i_address,
   input  logic                       i_write,
   input  logic [DATA_WIDTH-1:0]      i_write_data,
   input  logic [DATA_WIDTH/8-1:0]    i_strobe,
   output logic                       o_response_valid,
   input  logic                       i_response_ready,
   output logic [DATA_WIDTH-1:0]      o_read_data,
   output rggen_status                o_status,
   rggen_register_if.master           register_if [REGISTERS]
);

   localparam int STROBE_WIDTH = DATA_WIDTH / 8;

   rggen_host_state                     state;
   rggen_host_state                     next_state;
   logic [ADDRESS_WIDTH-1:0]            address_q;
   rggen_direction                      direction_q;
   logic [DATA_WIDTH-1:0]               write_data_q;
   logic [DATA_WIDTH-1:0]               write_mask_q;
   logic [DATA_WIDTH-1:0]               read_data_q;
   rggen_status                         status_q;
   logic                                first_busy;
   logic [DATA_WIDTH-1:0]               strobe_mask;
   logic                                capture;
   logic [DATA_WIDTH-1:0]               capture_read_data;
   rggen_status                         capture_status;
   logic                                timeout;

   logic [REGISTERS-1:0]                slot_select;
   logic [REGISTERS-1:0]                slot_ready;
   logic [REGISTERS-1:0][DATA_WIDTH-1:0] slot_read_data;
   rggen_status                         slot_status [REGISTERS];
   logic                                hit;
   logic                                multi_select;
   logic                                no_select;
   logic [DATA_WIDTH-1:0]               collected_read_data;
   rggen_status                         collected_status;

   // Every slot sees the same registered command; request is high only in
   // BUSY so it drops as soon as the response is captured.
   for (genvar g = 0; g < REGISTERS; g++) begin : g_slot
      assign register_if[g].request    = (state == BUSY);
      assign register_if[g].address    = address_q;
      assign register_if[g].direction  = direction_q;
      assign register_if[g].write_data = write_data_q;
      assign register_if[g].write_mask = write_mask_q;
      assign slot_select[g]            = register_if[g].select;
      assign slot_ready[g]             = register_if[g].ready;
      assign slot_read_data[g]         = register_if[g].read_data;
      assign slot_status[g]            = register_if[g].status;
   end

   rggen_response_collector #(
      .REGISTERS  (REGISTERS),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_collector (
      .select        (slot_select),
      .ready         (slot_ready),
      .read_data     (slot_read_data),
      .status        (slot_status),
      .hit           (hit),
      .multi_select  (multi_select),
      .no_select     (no_select),
      .merged_data   (collected_read_data),
      .merged_status (collected_status)
   );

   // Byte strobes become a bit-level write mask, one lane at a time.
   always_comb begin
      strobe_mask = '0;
      for (int b = 0; b < STROBE_WIDTH; b++) begin
         strobe_mask[8*b +: 8] = rggen_strobe_to_mask(i_strobe[b]);
      end
   end

`ifdef RGGEN_HOST_ADAPTER_TIMEOUT_EN
   localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

   logic [COUNT_WIDTH-1:0] busy_count;

   // Counts BUSY cycles already spent; holding it at zero outside BUSY means
   // every command starts from a cleared count.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_count <= '0;
      end else if (state != BUSY) begin
         busy_count <= '0;
      end else begin
         busy_count <= busy_count + COUNT_WIDTH'(1);
      end
   end

   assign timeout = (state == BUSY) &&
                    (busy_count == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   // Next-state and response selection. In BUSY the checks are ordered so a
   // multiple select always errors, a clean hit beats a simultaneous timeout,
   // and an empty decode only counts as a miss in the first BUSY cycle.
   always_comb begin
      next_state        = state;
      capture           = 1'b0;
      capture_read_data = '0;
      capture_status    = RGGEN_OKAY;
      case (state)
         IDLE: begin
            if (i_command_valid) begin
               next_state = BUSY;
            end
         end
         BUSY: begin
            if (multi_select) begin
               capture        = 1'b1;
               capture_status = RGGEN_SLAVE_ERROR;
            end else if (hit) begin
               capture        = 1'b1;
               capture_status = collected_status;
               if ((direction_q == RGGEN_READ) && (collected_status == RGGEN_OKAY)) begin
                  capture_read_data = collected_read_data;
               end
            end else if (no_select && first_busy) begin
               capture        = 1'b1;
               capture_status = RGGEN_SLAVE_ERROR;
            end else if (timeout) begin
               capture        = 1'b1;
               capture_status = RGGEN_SLAVE_ERROR;
            end
            if (capture) begin
               next_state = RESPONSE;
            end
         end
         RESPONSE: begin
            if (i_response_ready) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State, command and response registers. The command is latched only on
   // the IDLE handshake so the slots see it unchanged for the whole access.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         address_q    <= '0;
         direction_q  <= RGGEN_READ;
         write_data_q <= '0;
         write_mask_q <= '0;
         read_data_q  <= '0;
         status_q     <= RGGEN_OKAY;
         first_busy   <= 1'b0;
      end else begin
         state      <= next_state;
         first_busy <= (state == IDLE);
         if ((state == IDLE) && i_command_valid) begin
            address_q    <= i_address;
            direction_q  <= i_write ? RGGEN_WRITE : RGGEN_READ;
            write_data_q <= i_write_data;
            write_mask_q <= strobe_mask;
         end
         if (capture) begin
            read_data_q <= capture_read_data;
            status_q    <= capture_status;
         end
      end
   end

   assign o_command_ready  = (state == IDLE);
   assign o_response_valid = (state == RESPONSE);
   assign o_read_data      = read_data_q;
   assign o_status         = status_q;

endmodule

// File: tb/tb_rggen_host_adapter.sv
// ----------------------------------------------------------------------------
// tb_rggen_host_adapter
//
// Two behavioural register slots sit on the adapter's interface array. Each
// slot decodes one base address, can stall ready for a configured number of
// cycles, can answer with SLAVE_ERROR, and stores writes through the mask.
// Unselected slots drive scrambled read data so ungated muxing shows up.
// With RGGEN_HOST_ADAPTER_TIMEOUT_EN defined the timeout path is exercised.
// ----------------------------------------------------------------------------
module tb_rggen_host_adapter;
   import rggen_rtl_pkg::*;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int NS = 2;

   logic           clk;
   logic           rst;
   logic           i_command_valid;
   logic           o_command_ready;
   logic [AW-1:0]  i_address;
   logic           i_write;
   logic [DW-1:0]  i_write_data;
   logic [DW/8-1:0] i_strobe;
   logic           o_response_valid;
   logic           i_response_ready;
   logic [DW-1:0]  o_read_data;
   rggen_status    o_status;

   int total = 0;
   int bad   = 0;

   rggen_register_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) reg_if [NS] ();

   rggen_host_adapter #(
      .ADDRESS_WIDTH  (AW),
      .DATA_WIDTH     (DW),
      .REGISTERS      (NS),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .i_command_valid  (i_command_valid),
      .o_command_ready  (o_command_ready),
      .i_address        (i_address),
      .i_write          (i_write),
      .i_write_data     (i_write_data),
      .i_strobe         (i_strobe),
      .o_response_valid (o_response_valid),
      .i_response_ready (i_response_ready),
      .o_read_data      (o_read_data),
      .o_status         (o_status),
      .register_if      (reg_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slot environment
   logic [AW-1:0]   base_addr [NS];
   int              wait_cfg  [NS];
   bit              err_cfg   [NS];
   int              wait_cnt  [NS];
   logic [DW-1:0]   slot_mem  [NS];
   logic [NS-1:0]   slot_req;
   logic [NS-1:0]   slot_sel;
   logic [NS-1:0]   slot_rdy;
   logic [AW-1:0]   slot_addr  [NS];
   rggen_direction  slot_dir   [NS];
   logic [DW-1:0]   slot_wdata [NS];
   logic [DW-1:0]   slot_wmask [NS];

   localparam logic [DW-1:0] INIT0 = 32'hDEADBEEF;
   localparam logic [DW-1:0] INIT1 = 32'hCAFEF00D;

   for (genvar s = 0; s < NS; s++) begin : g_slot
      assign slot_req[s]        = reg_if[s].request;
      assign slot_addr[s]       = reg_if[s].address;
      assign slot_dir[s]        = reg_if[s].direction;
      assign slot_wdata[s]      = reg_if[s].write_data;
      assign slot_wmask[s]      = reg_if[s].write_mask;
      assign slot_sel[s]        = slot_req[s] && (slot_addr[s] == base_addr[s]);
      assign slot_rdy[s]        = slot_sel[s] && (wait_cnt[s] >= wait_cfg[s]);
      assign reg_if[s].select    = slot_sel[s];
      assign reg_if[s].ready     = slot_rdy[s];
      assign reg_if[s].read_data = slot_sel[s] ? slot_mem[s] : (slot_mem[s] ^ 32'hA5A55A5A);
      assign reg_if[s].status    = err_cfg[s] ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
   end

   // Slot storage and stall counters
   always @(posedge clk) begin
      for (int s = 0; s < NS; s++) begin
         if (rst) begin
            slot_mem[s] <= (s == 0) ? INIT0 : INIT1;
            wait_cnt[s] <= 0;
         end else begin
            wait_cnt[s] <= (slot_sel[s] && !slot_rdy[s]) ? wait_cnt[s] + 1 : 0;
            if (slot_rdy[s] && (slot_dir[s] == RGGEN_WRITE) && !err_cfg[s]) begin
               slot_mem[s] <= (slot_mem[s] & ~slot_wmask[s]) | (slot_wdata[s] & slot_wmask[s]);
            end
         end
      end
   end

   // Reference model state
   logic [DW-1:0] model_mem [NS];

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] ref_mask(input logic [3:0] st);
      logic [DW-1:0] m;
      m = '0;
      for (int b = 0; b < 4; b++) begin
         if (st[b]) m = m | (32'hFF << (8 * b));
      end
      return m;
   endfunction

   // Expected response from the decoding rules: zero or several decoding
   // slots give an error in two cycles, one slot answers after its stall.
   task automatic model_response(input logic [AW-1:0] addr, input bit wr, input logic [DW-1:0] wd,
                                 input logic [3:0] st, output logic [DW-1:0] ed,
                                 output logic [1:0] es, output int el);
      int hits;
      int idx;
      hits = 0;
      idx  = 0;
      for (int s = 0; s < NS; s++) begin
         if (base_addr[s] == addr) begin
            hits++;
            idx = s;
         end
      end
      ed = '0;
      es = RGGEN_SLAVE_ERROR;
      el = 2;
      if (hits == 1) begin
         el = wait_cfg[idx] + 2;
         if (!err_cfg[idx]) begin
            es = RGGEN_OKAY;
            if (wr) begin
               for (int b = 0; b < 4; b++) begin
                  if (st[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
               end
            end else begin
               ed = model_mem[idx];
            end
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      i_command_valid  = 1'b0;
      i_response_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_mem[0] = INIT0;
      model_mem[1] = INIT1;
   endtask

   // Issues one command, follows it through BUSY and returns what the slots
   // and the response channel showed. bp stalls the response handshake.
   task automatic apply_stimulus(input logic [AW-1:0] addr, input bit wr, input logic [DW-1:0] wd,
                                 input logic [3:0] st, input int bp,
                                 output logic [DW-1:0] rd, output logic [1:0] rs, output int lat,
                                 output int req_cycles, output logic [DW-1:0] seen_mask,
                                 output logic seen_dir, output logic [DW-1:0] seen_wdata);
      int unstable;
      bit got;
      unstable = 0;
      got = 0;
      lat = 0;
      req_cycles = 0;
      rd = '0;
      rs = '0;
      seen_mask = '0;
      seen_dir = 1'b0;
      seen_wdata = '0;
      @(negedge clk);
      check_output("command_ready_idle", o_command_ready, 1);
      i_command_valid = 1'b1;
      i_address = addr;
      i_write = wr;
      i_write_data = wd;
      i_strobe = st;
      @(posedge clk);
      for (int c = 0; c < 60 && !got; c++) begin
         @(negedge clk);
         i_command_valid = 1'b0;
         i_address = AW'($urandom);
         i_write_data = $urandom;
         i_strobe = 4'($urandom);
         i_write = 1'($urandom);
         lat++;
         if (o_response_valid) begin
            got = 1;
         end else if (slot_req[0]) begin
            if (req_cycles == 0) begin
               seen_mask = slot_wmask[0];
               seen_dir = slot_dir[0];
               seen_wdata = slot_wdata[0];
            end
            req_cycles++;
            for (int s = 0; s < NS; s++) begin
               if (slot_req[s] !== 1'b1 || slot_addr[s] !== addr || slot_wdata[s] !== wd ||
                   slot_wmask[s] !== seen_mask || slot_dir[s] !== seen_dir) unstable++;
            end
         end
      end
      if (!got) begin
         check_output("response_arrived", 0, 1);
         return;
      end
      rd = o_read_data;
      rs = o_status;
      check_output("request_stable", unstable, 0);
      check_output("request_dropped", slot_req, 0);
      for (int c = 0; c < bp; c++) begin
         i_command_valid = 1'b1;
         i_address = 16'h0004;
         i_write = 1'b0;
         @(negedge clk);
         check_output("bp_valid_held", o_response_valid, 1);
         check_output("bp_data_held", o_read_data, rd);
         check_output("bp_status_held", o_status, rs);
         check_output("bp_command_ready", o_command_ready, 0);
         check_output("bp_no_request", slot_req, 0);
      end
      i_command_valid = 1'b0;
      i_response_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_response_ready = 1'b0;
      check_output("response_released", o_response_valid, 0);
   endtask

   typedef struct {
      logic [AW-1:0] addr;
      bit            wr;
      logic [DW-1:0] wd;
      logic [3:0]    st;
      int            w0;
      int            w1;
      bit            e1;
      logic [DW-1:0] exp_data;
      logic [1:0]    exp_status;
      int            exp_lat;
   } vec_t;

   vec_t vecs [9];

   task automatic compare_run(input string tag, input logic [AW-1:0] addr, input bit wr,
                              input logic [DW-1:0] wd, input logic [3:0] st, input int bp,
                              input logic [DW-1:0] ed, input logic [1:0] es, input int el);
      logic [DW-1:0] rd, sm, sw;
      logic [1:0] rs;
      logic sd;
      int lat, rc;
      apply_stimulus(addr, wr, wd, st, bp, rd, rs, lat, rc, sm, sd, sw);
      check_output({tag, "_data"}, rd, ed);
      check_output({tag, "_status"}, rs, es);
      check_output({tag, "_latency"}, lat, el);
      check_output({tag, "_request_cycles"}, rc, el - 1);
      check_output({tag, "_mask"}, sm, ref_mask(st));
      check_output({tag, "_direction"}, sd, wr);
      check_output({tag, "_write_data"}, sw, wd);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: actual=expired required=finished");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] ed;
      logic [1:0] es;
      int el;
      int responses;

      rst = 1'b1;
      i_command_valid = 1'b0;
      i_address = '0;
      i_write = 1'b0;
      i_write_data = '0;
      i_strobe = '0;
      i_response_ready = 1'b0;
      base_addr[0] = 16'h0010;
      base_addr[1] = 16'h0004;
      wait_cfg[0] = 0;
      wait_cfg[1] = 0;
      err_cfg[0] = 0;
      err_cfg[1] = 0;
      model_mem[0] = INIT0;
      model_mem[1] = INIT1;

      // Reset values
      repeat (3) @(negedge clk);
      check_output("reset_command_ready", o_command_ready, 1);
      check_output("reset_response_valid", o_response_valid, 0);
      check_output("reset_read_data", o_read_data, 0);
      check_output("reset_status", o_status, RGGEN_OKAY);
      check_output("reset_request", slot_req, 0);
      check_output("reset_address", slot_addr[0], 0);
      check_output("reset_write_data", slot_wdata[0], 0);
      check_output("reset_write_mask", slot_wmask[0], 0);
      check_output("reset_direction", slot_dir[0], RGGEN_READ);
      rst = 1'b0;

      // Directed table
      vecs[0] = '{16'h0010, 0, 32'h0,        4'b0000, 0, 0, 0, 32'hDEADBEEF, RGGEN_OKAY,        2};
      vecs[1] = '{16'h0004, 1, 32'h12345678, 4'b0101, 0, 0, 0, 32'h0,        RGGEN_OKAY,        2};
      vecs[2] = '{16'h0080, 0, 32'h0,        4'b0000, 0, 0, 0, 32'h0,        RGGEN_SLAVE_ERROR, 2};
      vecs[3] = '{16'h0004, 0, 32'h0,        4'b0000, 0, 0, 1, 32'h0,        RGGEN_SLAVE_ERROR, 2};
      vecs[4] = '{16'h0004, 0, 32'h0,        4'b0000, 0, 2, 0, 32'hCA34F078, RGGEN_OKAY,        4};
      vecs[5] = '{16'h0010, 1, 32'h0BADF00D, 4'b1111, 0, 0, 0, 32'h0,        RGGEN_OKAY,        2};
      vecs[6] = '{16'h0010, 0, 32'h0,        4'b0000, 5, 0, 0, 32'h0BADF00D, RGGEN_OKAY,        7};
      vecs[7] = '{16'h0004, 1, 32'hAABBCCDD, 4'b1000, 0, 1, 1, 32'h0,        RGGEN_SLAVE_ERROR, 3};
      vecs[8] = '{16'h0004, 0, 32'h0,        4'b0000, 0, 0, 0, 32'hCA34F078, RGGEN_OKAY,        2};
      for (int i = 0; i < 9; i++) begin
         wait_cfg[0] = vecs[i].w0;
         wait_cfg[1] = vecs[i].w1;
         err_cfg[1]  = vecs[i].e1;
         compare_run($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wr, vecs[i].wd, vecs[i].st, 0,
                     vecs[i].exp_data, vecs[i].exp_status, vecs[i].exp_lat);
      end
      wait_cfg[0] = 0;
      wait_cfg[1] = 0;
      err_cfg[1] = 0;

      // Two slots decoding the same address
      do_reset();
      base_addr[1] = 16'h0010;
      compare_run("multi_select", 16'h0010, 0, 32'h0, 4'b0000, 0, 32'h0, RGGEN_SLAVE_ERROR, 2);
      base_addr[1] = 16'h0004;

      // Response backpressure with a competing command held valid
      model_response(16'h0010, 0, 32'h0, 4'b0000, ed, es, el);
      compare_run("backpressure", 16'h0010, 0, 32'h0, 4'b0000, 4, ed, es, el);

      // Reset while BUSY drops the access without a response
      wait_cfg[0] = 5;
      @(negedge clk);
      i_command_valid = 1'b1;
      i_address = 16'h0010;
      i_write = 1'b0;
      @(posedge clk);
      @(negedge clk);
      i_command_valid = 1'b0;
      check_output("busy_before_reset", slot_req[0], 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_output("rst_busy_request", slot_req, 0);
      check_output("rst_busy_response_valid", o_response_valid, 0);
      check_output("rst_busy_command_ready", o_command_ready, 1);
      check_output("rst_busy_address", slot_addr[0], 0);
      model_mem[0] = INIT0;
      model_mem[1] = INIT1;
      responses = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (o_response_valid || slot_req != 0) responses++;
      end
      check_output("rst_busy_no_response", responses, 0);
      wait_cfg[0] = 0;
      compare_run("after_reset", 16'h0010, 0, 32'h0, 4'b0000, 0, INIT0, RGGEN_OKAY, 2);

      // Randomized commands against the reference model
      do_reset();
      for (int i = 0; i < 30; i++) begin
         logic [AW-1:0] a;
         bit w;
         logic [DW-1:0] d;
         logic [3:0] st;
         case ($urandom_range(0, 3))
            0: a = 16'h0010;
            1: a = 16'h0004;
            2: a = 16'h0080;
            default: a = AW'($urandom_range(16'h0100, 16'hFFFF));
         endcase
         w = 1'($urandom_range(0, 1));
         d = $urandom;
         st = 4'($urandom);
         for (int s = 0; s < NS; s++) begin
            wait_cfg[s] = $urandom_range(0, 3);
            err_cfg[s] = ($urandom_range(0, 7) == 0);
         end
         model_response(a, w, d, st, ed, es, el);
         compare_run($sformatf("rand%0d", i), a, w, d, st, $urandom_range(0, 2), ed, es, el);
      end
      err_cfg[0] = 0;
      err_cfg[1] = 0;

`ifdef RGGEN_HOST_ADAPTER_TIMEOUT_EN
      // Slot never readies: error after eight BUSY cycles
      wait_cfg[0] = 1000;
      wait_cfg[1] = 0;
      compare_run("timeout", 16'h0010, 0, 32'h0, 4'b0000, 0, 32'h0, RGGEN_SLAVE_ERROR, 9);
      wait_cfg[0] = 0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rggen_host_adapter.md
Name: rggen_host_adapter

Overview:
- Host-side initiator for rggen_register_if. It accepts one host command at a time over a valid/ready channel.
- It drives request, address, direction, write data and write mask to every register slot. It then collects select/ready/read_data/status from the slots and returns one response over a valid/ready channel.
- It sits between the bus protocol front-ends (APB/AXI-Lite shims) and the register array, and is the master end of the same interface the register blocks answer on.

Parameters:
- ADDRESS_WIDTH, 16, byte address width driven onto register_if.address
- DATA_WIDTH, 32, data width; must be a multiple of 8
- REGISTERS, 1, number of register_if slots attached
- TIMEOUT_CYCLES, 255, max BUSY cycles before forced error; used only when the optional feature is compiled in; must be >= 1

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- i_command_valid  input  1  host command present
- o_command_ready  output  1  adapter accepts command
- i_address  input  ADDRESS_WIDTH  byte address
- i_write  input  1  1 = write, 0 = read
- i_write_data  input  DATA_WIDTH  write data
- i_strobe  input  DATA_WIDTH/8  byte enables
- o_response_valid  output  1  response present
- i_response_ready  input  1  host accepts response
- o_read_data  output  DATA_WIDTH  read data; 0 for writes and errors
- o_status  output  rggen_status  RGGEN_OKAY or RGGEN_SLAVE_ERROR
- register_if[REGISTERS]  rggen_register_if.master  request/address/direction/write_data/write_mask out; select/ready/read_data/status in

Behaviour:
- States are IDLE, BUSY and RESPONSE, encoded 2-bit one-hot-free. Reset state is IDLE.
- Reset values:
  - o_command_ready = 1
  - o_response_valid = 0
  - o_read_data = 0
  - o_status = RGGEN_OKAY
  - request = 0, address = 0, write_data = 0, write_mask = 0, direction = RGGEN_READ
- IDLE:
  - o_command_ready = 1.
  - When valid&&ready, register address, direction (i_write ? RGGEN_WRITE : RGGEN_READ), write_data, and write_mask. write_mask is i_strobe with each bit replicated 8x.
  - Go to BUSY.
- BUSY:
  - request = 1 to all slots; all slots see identical address/direction/data/mask. o_command_ready = 0.
  - Each cycle, compute hit = OR over slots of (select && ready).
  - Zero selects in the first BUSY cycle: decode miss. Capture status SLAVE_ERROR and read_data 0, then go to RESPONSE.
  - Exactly one select and hit: capture that slot's status. Capture read_data only if direction is READ and status is OKAY, else 0. Go to RESPONSE.
  - More than one select in the same cycle: capture SLAVE_ERROR and read_data 0, then go to RESPONSE. No slot write is suppressed; the slots decide that.
  - Select held without ready: stay in BUSY, all outputs held stable.
- RESPONSE:
  - request = 0, o_response_valid = 1. o_read_data and o_status are held stable until i_response_ready.
  - On handshake, go to IDLE.
  - o_command_ready stays 0, so no new command overlaps a pending response.
- Latency with a single-cycle slot (ready in the same cycle as request):
  - command handshake in cycle N
  - request high in cycle N+1
  - response_valid in cycle N+2
- Best-case throughput is one command per 3 cycles; this is acceptable.
- rst asserted in any state forces IDLE and the reset values on the next edge. An in-flight request is dropped and no response is issued.
- Read-data mux is an AND-OR over slots gated by select. Width is exactly DATA_WIDTH; no truncation.

Optional Feature:
- Macro: RGGEN_HOST_ADAPTER_TIMEOUT_EN.
- Compiled in: a counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without a hit, request drops and SLAVE_ERROR is returned with read_data 0.
  - A hit in the same cycle as timeout wins; the normal response is returned.
- Compiled out: no counter, and BUSY waits indefinitely on select-without-ready.

Decomposition:
- rggen_rtl_pkg additions:
  - typedef rggen_host_state (IDLE/BUSY/RESPONSE)
  - function rggen_strobe_to_mask(strobe)
- rggen_status and rggen_direction are already defined there.
- One sub-module: rggen_response_collector. It is combinational: it takes the slot select/ready/read_data/status vectors and produces hit, multi_select, no_select, read_data and status.

Test Plan:
- Read, one slot at 0x10 with value 0xDEADBEEF, ready same cycle:
  - request high exactly 1 cycle
  - response at N+2: data 0xDEADBEEF, status OKAY
- Write 0x12345678 with strobe 4'b0101 to 0x04:
  - slot sees write_mask 0x00FF00FF, direction WRITE
  - response: data 0, OKAY
- Read 0x80 with no slot decoding it: response at N+2 with SLAVE_ERROR, data 0.
- Slot holds ready low 5 cycles:
  - request held 6 cycles with address/data stable
  - response on the 6th cycle's hit
- Response backpressure: i_response_ready low 4 cycles.
  - valid/data/status held stable
  - command_ready stays 0
  - second command is accepted only after the response handshake
- rst pulsed while in BUSY: next cycle request=0, response_valid=0, command_ready=1, and no response is emitted.
- With RGGEN_HOST_ADAPTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, slot never readies: SLAVE_ERROR after 8 BUSY cycles, and request deasserts.
